// File: rtl/detect_winner_scan_if.sv
// Handshake and board bundle between the move controller (master) and the
// sequential winner scanner (slave).
interface detect_winner_scan_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7
);
  logic                 start;
  logic [ROWS*COLS-1:0] game_board;
  logic [ROWS*COLS-1:0] player_cells;
  logic                 busy;
  logic                 done;
  logic [1:0]           game_status;
  logic [ROWS*COLS-1:0] win_mask;

  modport master (
    output start, game_board, player_cells,
    input  busy, done, game_status, win_mask
  );

  modport slave (
    input  start, game_board, player_cells,
    output busy, done, game_status, win_mask
  );
endinterface

// File: rtl/detect_winner_scan.sv
// Sequential WIN_LEN-in-a-row judge: snapshots the board on start, scans one
// anchor cell per clock (H, V, DUR, DUL priority) and reports once.
module detect_winner_scan #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  detect_winner_scan_if.slave  bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Cells of the line starting at (r,c) stepping (dr,dc); empty if it leaves the board.
  function automatic logic [N-1:0] line_mask(input int r, input int c, input int dr, input int dc);
    logic [N-1:0] m;
    logic         fits;
    int           rr;
    int           cc;
    m    = {N{1'b0}};
    fits = 1'b1;
    for (int k = 0; k < WIN_LEN; k++) begin
      rr = r + k * dr;
      cc = c + k * dc;
      if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
        fits = 1'b0;
      end else begin
        m[IDX_W'(rr * COLS + cc)] = 1'b1;
      end
    end
    return fits ? m : {N{1'b0}};
  endfunction

  function automatic logic line_hit(input logic [N-1:0] m, input logic [N-1:0] board,
                                    input logic [N-1:0] cells, input logic owner);
    return (m != {N{1'b0}}) && ((board & m) == m) &&
           ((cells & m) == (owner ? m : {N{1'b0}}));
  endfunction

  state_t         state_r, state_next_s;
  logic [N-1:0]   board_r, cells_r;
  logic [RW-1:0]  row_r;
  logic [CW-1:0]  col_r;
  logic           busy_r, done_r;
  logic [1:0]     status_r;
  logic [N-1:0]   mask_r;

  logic [IDX_W-1:0] anchor_idx_s;
  logic             owner_s;
  logic [N-1:0]     mask_h_s, mask_v_s, mask_dur_s, mask_dul_s, hit_mask_s;
  logic [3:0]       hit_s;
  logic             any_hit_s, last_s;
  logic             busy_next_s, done_next_s;
  logic [1:0]       status_next_s;
  logic [N-1:0]     mask_next_s;

  // Evaluate all four directions for the current anchor and pick by priority.
  always_comb begin
    anchor_idx_s = IDX_W'(int'(row_r) * COLS + int'(col_r));
    owner_s      = cells_r[anchor_idx_s];
    mask_h_s     = line_mask(int'(row_r), int'(col_r), 0, 1);
    mask_v_s     = line_mask(int'(row_r), int'(col_r), 1, 0);
    mask_dur_s   = line_mask(int'(row_r), int'(col_r), 1, 1);
    mask_dul_s   = line_mask(int'(row_r), int'(col_r), 1, -1);
    hit_s[0]     = line_hit(mask_h_s,   board_r, cells_r, owner_s);
    hit_s[1]     = line_hit(mask_v_s,   board_r, cells_r, owner_s);
    hit_s[2]     = line_hit(mask_dur_s, board_r, cells_r, owner_s);
    hit_s[3]     = line_hit(mask_dul_s, board_r, cells_r, owner_s);
    any_hit_s    = |hit_s;
    last_s       = (row_r == RW'(ROWS - 1)) && (col_r == CW'(COLS - 1));
    if (hit_s[0]) begin
      hit_mask_s = mask_h_s;
    end else if (hit_s[1]) begin
      hit_mask_s = mask_v_s;
    end else if (hit_s[2]) begin
      hit_mask_s = mask_dur_s;
    end else if (hit_s[3]) begin
      hit_mask_s = mask_dul_s;
    end else begin
      hit_mask_s = {N{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = bus.start ? SCAN : IDLE;
      SCAN:    state_next_s = (any_hit_s || last_s) ? REPORT : SCAN;
      REPORT:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Snapshot capture and row/column anchor walk; the walk stops at the last cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      board_r <= {N{1'b0}};
      cells_r <= {N{1'b0}};
      row_r   <= {RW{1'b0}};
      col_r   <= {CW{1'b0}};
    end else if (state_r == IDLE && bus.start) begin
      board_r <= bus.game_board;
      cells_r <= bus.player_cells;
      row_r   <= {RW{1'b0}};
      col_r   <= {CW{1'b0}};
    end else if (state_r == SCAN && !any_hit_s && !last_s) begin
      if (col_r == CW'(COLS - 1)) begin
        col_r <= {CW{1'b0}};
        row_r <= row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end else begin
      row_r <= row_r;
      col_r <= col_r;
    end
  end

  // Next values of the registered outputs; results hold outside the scan exit.
  always_comb begin
    busy_next_s   = busy_r;
    done_next_s   = 1'b0;
    status_next_s = status_r;
    mask_next_s   = mask_r;
    case (state_r)
      IDLE: begin
        busy_next_s = bus.start;
      end
      SCAN: begin
        if (any_hit_s) begin
          busy_next_s   = 1'b0;
          done_next_s   = 1'b1;
          status_next_s = owner_s ? 2'b10 : 2'b01;
          mask_next_s   = hit_mask_s;
        end else if (last_s) begin
          busy_next_s   = 1'b0;
          done_next_s   = 1'b1;
          status_next_s = (&board_r) ? 2'b11 : 2'b00;
          mask_next_s   = {N{1'b0}};
        end else begin
          busy_next_s = 1'b1;
        end
      end
      REPORT: begin
        busy_next_s = 1'b0;
      end
      default: begin
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      status_r <= 2'b00;
      mask_r   <= {N{1'b0}};
    end else begin
      busy_r   <= busy_next_s;
      done_r   <= done_next_s;
      status_r <= status_next_s;
      mask_r   <= mask_next_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.game_status = status_r;
  assign bus.win_mask    = mask_r;
endmodule
